// File: rtl/ifetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of {pc, instr} pairs between fetch and decode.
// Flush beats push/pop; push together with pop is accepted when full.
module fetch_buf
    import ifetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic [$clog2(BUF_DEPTH):0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(BUF_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset on purpose so the head outputs read zero
            // after reset; drop this loop if the memory must map to RAM macros.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: PC register, imem address drive, redirect/fault control,
// and a small buffer presenting {pc, instr} to decode over valid/ready.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            running;
    logic            pop;
    logic            push;
    logic            flush;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count_unused;
    fetch_entry_t    buf_din;
    fetch_entry_t    buf_dout;

    assign running   = (state == RUN);
    assign imem_addr = pc;
    assign out_valid = running && !buf_empty;
    assign pop       = out_valid && out_ready;
    // Any redirect seen in RUN empties the buffer, aligned or not.
    assign flush     = running && redirect_valid;
    assign push      = running && !redirect_valid && (!buf_full || pop);
    assign buf_din   = '{pc: pc, instr: imem_rdata};
    assign out_pc    = buf_dout.pc;
    assign out_instr = buf_dout.instr;

    fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (buf_din),
        .dout  (buf_dout),
        .count (buf_count_unused),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (running) begin
            if (redirect_valid) begin
                if (is_word_aligned(redirect_pc)) begin
                    pc <= redirect_pc;
                end else begin
                    // pc is left alone so imem_addr keeps the last fetch address.
                    state    <= FAULT;
                    fault    <= 1'b1;
                    fault_pc <= redirect_pc;
                end
            end else if (push) begin
                pc <= pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: imem model returns addr ^ 32'hA5A5_0000.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    ifetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, halfway between active edges.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".pc"}, out_pc, exp_pc);
        check({tag, ".instr"}, out_instr, exp_pc ^ 32'hA5A5_0000);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.imem_addr", imem_addr, 32'h0);
        check("rst.out_pc", out_pc, 32'h0);
        check("rst.out_instr", out_instr, 32'h0);
        check("rst.fault", {31'd0, fault}, 32'd0);
        check("rst.fault_pc", fault_pc, 32'h0);

        // Streaming with out_ready = 1: one instruction per cycle
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_head($sformatf("stream%0d", i), 32'(4 * i));
            check($sformatf("stream%0d.imem_addr", i), imem_addr, 32'(4 * i + 4));
        end

        // Back-pressure from reset: buffer fills, pc freezes at 8
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_head($sformatf("stall%0d", i), 32'h0);
        end
        check("stall.imem_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        tick();
        check_head("drain4", 32'h4);
        check("drain4.imem_addr", imem_addr, 32'hC);
        tick();
        check_head("drain8", 32'h8);
        check("drain8.imem_addr", imem_addr, 32'h10);

        // Aligned redirect at pc 0x10 in the same cycle as a pop
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("redir.valid", {31'd0, out_valid}, 32'd0);
        check("redir.imem_addr", imem_addr, 32'h200);
        tick();
        check_head("redir200", 32'h200);
        check("redir200.imem_addr", imem_addr, 32'h204);
        tick();
        check_head("redir204", 32'h204);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("wrap.valid", {31'd0, out_valid}, 32'd0);
        check("wrap.imem_addr", imem_addr, 32'hFFFF_FFF8);
        tick();
        check_head("wrapF8", 32'hFFFF_FFF8);
        tick();
        check_head("wrapFC", 32'hFFFF_FFFC);
        tick();
        check_head("wrap00", 32'h0000_0000);
        tick();
        check_head("wrap04", 32'h0000_0004);
        check("wrap04.imem_addr", imem_addr, 32'h8);

        // Misaligned redirect: sticky fault, pc holds
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        check("fault.fault", {31'd0, fault}, 32'd1);
        check("fault.fault_pc", fault_pc, 32'h102);
        check("fault.valid", {31'd0, out_valid}, 32'd0);
        check("fault.imem_addr", imem_addr, 32'h8);
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("fault_ign.imem_addr", imem_addr, 32'h8);
        check("fault_ign.valid", {31'd0, out_valid}, 32'd0);
        check("fault_ign.fault", {31'd0, fault}, 32'd1);
        check("fault_ign.fault_pc", fault_pc, 32'h102);
        tick();
        check("fault_hold.valid", {31'd0, out_valid}, 32'd0);
        check("fault_hold.imem_addr", imem_addr, 32'h8);
        rst = 1'b1;
        tick();
        check("fault_rst.imem_addr", imem_addr, 32'h0);
        check("fault_rst.fault", {31'd0, fault}, 32'd0);
        check("fault_rst.fault_pc", fault_pc, 32'h0);
        check("fault_rst.valid", {31'd0, out_valid}, 32'd0);

        // Reset while full with a redirect pending
        rst       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check_head("full", 32'h0);
        check("full.imem_addr", imem_addr, 32'h8);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        check("rst_full.valid", {31'd0, out_valid}, 32'd0);
        check("rst_full.imem_addr", imem_addr, 32'h0);
        check("rst_full.fault", {31'd0, fault}, 32'd0);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        check_head("after_rst0", 32'h0);
        check("after_rst0.imem_addr", imem_addr, 32'h4);
        tick();
        check_head("after_rst4", 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
